serial_zero_cmp: RTL
====================

// Module: serial_zero_cmp
// PURPOSE
//  Sequencer feeding the 4-input NOR zero-detect cells. Accepts a WIDTH-bit word, or the XOR of two words,
//  and evaluates one 4-bit slice per clock through a 4-input NOR.
//  Accumulates an all-zero / equal flag for the branch-compare and zero-flag paths.
//  Returns that flag with a valid/ready handshake.
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//  NIB    WIDTH/4  derived slice count; not overridable
// PORTS
//  clk         in   1                    single clock, rising edge
//  rst         in   1                    synchronous, active-high reset
//  req_valid   in   1                    request present
//  req_ready   out  1                    block can accept a request
//  req_mode    in   1                    0: test req_a==0; 1: test req_a==req_b
//  req_a       in   WIDTH                operand A
//  req_b       in   WIDTH                operand B (ignored when req_mode=0)
//  rsp_valid   out  1                    result present
//  rsp_ready   in   1                    consumer takes result
//  rsp_zero    out  1                    1 = all slices zero (A==0 or A==B)
//  rsp_cycles  out  $clog2(NIB+1)        number of slices evaluated
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - Reset values:
//    - state=IDLE, rsp_valid=0, rsp_zero=0, rsp_cycles=0.
//    - req_ready = (state==IDLE) && !rst, so it reads 0 while rst is high.
//  - IDLE
//    - req_ready=1.
//    - On req_valid&&req_ready: latch word = req_mode ? req_a^req_b : req_a; idx=0; acc=1; go to SCAN.
//  - SCAN
//    - req_ready=0.
//    - Each cycle: nor = ~|word[4*idx +: 4]; acc <= acc & nor; idx <= idx+1.
//    - Slice 0 (LSBs) is evaluated first.
//    - When idx==NIB-1, the final acc update is taken and the state goes to DONE.
//  - DONE
//    - rsp_valid=1, rsp_zero=acc, rsp_cycles=slices evaluated.
//    - All three outputs stay stable until rsp_ready=1; on rsp_valid&&rsp_ready go to IDLE.
//    - A new request is accepted no earlier than the following cycle.
//  - Latency, acceptance edge to rsp_valid: NIB+1 cycles. Throughput: one result per NIB+2 cycles.
//  - req_valid during SCAN/DONE is ignored; the requester must hold it until accepted.
//  - Reset mid-SCAN or mid-DONE aborts the operation; no response is produced. IDLE follows the reset cycle.
//  - WIDTH=4 (NIB=1): SCAN lasts exactly one cycle.
// CONFIGURATION
//  - SERIAL_ZERO_CMP_EARLY_EXIT_EN defined:
//    - In SCAN, a slice with nor==0 sends the state straight to DONE, with acc=0 and rsp_cycles=idx+1.
//    - Latency becomes data-dependent (min 2 cycles).
//  - Not defined: SCAN always evaluates all NIB slices; rsp_cycles is always NIB.
// STRUCTURE
//  - Package rv523_zc_pkg: state enum zc_state_e {ZC_IDLE, ZC_SCAN, ZC_DONE}; localparam ZC_SLICE_W=4.
//  - Sub-module zc_nor4_slice: 4-bit input, 1-bit NOR output; behavioural model of one NOR4 cell.
//  - Top block: FSM, word register, idx counter, acc flop.
// TESTING (WIDTH=32)
//  1. mode0, a=0x00000000 -> rsp_valid 9 cycles after accept; rsp_zero=1, rsp_cycles=8.
//  2. mode0, a=0x80000000 -> rsp_zero=0, rsp_cycles=8 in both configs (nonzero bit is in the last slice).
//  3. mode1, a=b=0xDEADBEEF -> rsp_zero=1.
//     mode1, a=0xDEADBEEF, b=0xDEADBEEE -> rsp_zero=0; rsp_cycles=1 with EARLY_EXIT, 8 without.
//  4. Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_zero/rsp_cycles stable; req_ready=0; IDLE after the handshake.
//  5. Assert rst during SCAN cycle 3 -> next cycle: IDLE, rsp_valid=0, req_ready=1; no response ever issued.
//  6. req_valid held high through a busy period -> second request accepted only in IDLE; both results correct and in order.

Source files
------------

// File: rtl/rv523_zc_pkg.sv
// Package: rv523_zc_pkg
// Purpose: shared types and constants for the serial zero-compare sequencer.
//   zc_state_e  : sequencer state (IDLE -> SCAN -> DONE -> IDLE)
//   ZC_SLICE_W  : width of one slice fed to a NOR4 zero-detect cell
// Optional feature macro used by the top: SERIAL_ZERO_CMP_EARLY_EXIT_EN
package rv523_zc_pkg;

  localparam int ZC_SLICE_W = 4;

  typedef enum logic [1:0] {
    ZC_IDLE = 2'd0,
    ZC_SCAN = 2'd1,
    ZC_DONE = 2'd2
  } zc_state_e;

endpackage : rv523_zc_pkg

// File: rtl/zc_nor4_slice.sv
// Module: zc_nor4_slice
// Purpose: behavioural model of one 4-input NOR zero-detect cell.
// Ports:
//   i_slice  in  ZC_SLICE_W  slice under test
//   o_nor    out 1           1 when every bit of i_slice is zero
module zc_nor4_slice
  import rv523_zc_pkg::*;
(
  input  logic [ZC_SLICE_W-1:0] i_slice,
  output logic                  o_nor
);

  assign o_nor = ~|i_slice;

endmodule : zc_nor4_slice

// File: rtl/serial_zero_cmp.sv
// Module: serial_zero_cmp
// Purpose: sequencer feeding a NOR4 zero-detect cell. Accepts a WIDTH-bit
//   word (or the XOR of two words), evaluates one 4-bit slice per clock,
//   LSB slice first, and accumulates an all-zero / equal flag that is
//   returned through a valid/ready response port.
// Parameters:
//   WIDTH  operand width, multiple of 4 and >= 4 (checked at elaboration)
//   NIB    derived slice count WIDTH/4 (not overridable)
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   req_valid   in   1        request present
//   req_ready   out  1        sequencer idle and not in reset
//   req_mode    in   1        0: test req_a==0, 1: test req_a==req_b
//   req_a       in   WIDTH    operand A
//   req_b       in   WIDTH    operand B (ignored when req_mode=0)
//   rsp_valid   out  1        result present
//   rsp_ready   in   1        consumer takes result
//   rsp_zero    out  1        1 = all slices zero
//   rsp_cycles  out  CYC_W    number of slices evaluated
//   dbg_state   out  2        current sequencer state
// Configuration:
//   SERIAL_ZERO_CMP_EARLY_EXIT_EN  when defined, the first non-zero slice
//   ends the scan immediately; otherwise all NIB slices are always scanned.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised it is held, with its payload stable,
// until that transfer; ready may be raised or lowered at any time.
module serial_zero_cmp
  import rv523_zc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / ZC_SLICE_W,
  localparam int CYC_W = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_zero,
  output logic [CYC_W-1:0] rsp_cycles,
  output zc_state_e        dbg_state
);

  // A single-slice build still needs a one-bit index register.
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % ZC_SLICE_W) != 0 || WIDTH < ZC_SLICE_W) begin : g_width_check
    $error("serial_zero_cmp: WIDTH must be a multiple of 4 and >= 4");
  end

  zc_state_e        r_state;
  zc_state_e        w_next_state;
  logic [WIDTH-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_acc;
  logic [CYC_W-1:0] r_cycles;

  logic             w_accept;
  logic             w_nor;
  logic             w_last;

  // The word is shifted right after each slice, so the slice at the bottom
  // of r_word is always original word[4*idx +: 4]; one cell serves them all.
  zc_nor4_slice u_nor4 (
    .i_slice (r_word[ZC_SLICE_W-1:0]),
    .o_nor   (w_nor)
  );

  assign req_ready = (r_state == ZC_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_idx == IDX_W'(NIB - 1));

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ZC_IDLE: begin
        if (w_accept) w_next_state = ZC_SCAN;
      end
      ZC_SCAN: begin
`ifdef SERIAL_ZERO_CMP_EARLY_EXIT_EN
        if (!w_nor || w_last) w_next_state = ZC_DONE;
`else
        if (w_last) w_next_state = ZC_DONE;
`endif
      end
      ZC_DONE: begin
        if (rsp_ready) w_next_state = ZC_IDLE;
      end
      default: w_next_state = ZC_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ZC_IDLE;
      r_word   <= '0;
      r_idx    <= '0;
      r_acc    <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ZC_IDLE: begin
          if (w_accept) begin
            r_word   <= req_mode ? (req_a ^ req_b) : req_a;
            r_idx    <= '0;
            r_acc    <= 1'b1;
            r_cycles <= '0;
          end
        end
        ZC_SCAN: begin
          // On an early exit these same updates give acc=0 and
          // cycles=idx+1, so no separate path is needed.
          r_word   <= r_word >> ZC_SLICE_W;
          r_idx    <= r_idx + IDX_W'(1);
          r_acc    <= r_acc & w_nor;
          r_cycles <= CYC_W'(r_idx) + CYC_W'(1);
        end
        default: begin
          // DONE holds the result until it is taken.
        end
      endcase
    end
  end

  // Result outputs are forced low outside DONE so they read zero after reset.
  assign rsp_valid  = (r_state == ZC_DONE);
  assign rsp_zero   = rsp_valid && r_acc;
  assign rsp_cycles = rsp_valid ? r_cycles : '0;
  assign dbg_state  = r_state;

endmodule : serial_zero_cmp
